// File: rtl/demux1to4_stream.sv
// 1-to-4 stream demultiplexer with a one-entry register per output lane.
// Words are steered by in_sel or by a round-robin pointer that never skips a stalled slot.
module demux1to4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_mode,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr
);

  localparam logic [0:0] LANE_EMPTY = 1'b0;
  localparam logic [0:0] LANE_FULL  = 1'b1;

  logic [3:0]       vld;
  logic [WIDTH-1:0] dat [4];
  logic [1:0]       ptr_q;
  logic [1:0]       target;
  logic             accept;
  logic [3:0]       load;

  // A lane can take a word if it is empty or its current word leaves this cycle.
  always_comb begin
    target   = rr_mode ? ptr_q : in_sel;
    in_ready = rst_n & (!vld[target] | out_ready[target]);
    accept   = in_valid & in_ready;
    load     = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      load[i] = accept & (target == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        vld[i] <= LANE_EMPTY;
        dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          vld[i] <= LANE_FULL;
          dat[i] <= in_data;
        end else if (vld[i] && out_ready[i]) begin
          vld[i] <= LANE_EMPTY;
        end
      end
    end
  end

  // The pointer moves only on an accepted word, so a stalled slot holds it in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (accept && rr_mode) begin
      ptr_q <= ptr_q + 2'd1;
    end
  end

  assign out_valid = vld;
  assign out_data0 = dat[0];
  assign out_data1 = dat[1];
  assign out_data2 = dat[2];
  assign out_data3 = dat[3];
  assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream: reset, select routing, backpressure,
// round-robin stalls, mode toggling and mid-stream reset.
module tb_demux1to4_stream;

  logic       clk;
  logic       rst_n;
  logic       rr_mode;
  logic [1:0] in_sel;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data0;
  logic [7:0] out_data1;
  logic [7:0] out_data2;
  logic [7:0] out_data3;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;

  int testsRun = 0;
  int testsFailed = 0;

  demux1to4_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_mode   (rr_mode),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the rising edge, then settle before any check.
  task automatic applyStimulus(input logic rst, input logic mode, input logic [1:0] sel,
                               input logic v, input logic [7:0] data, input logic [3:0] ordy);
    rst_n     = rst;
    rr_mode   = mode;
    in_sel    = sel;
    in_valid  = v;
    in_data   = data;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [7:0] laneData(input int lane);
    case (lane)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  initial begin
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b1, 8'h5A, 4'b0000);
    tick();
    tick();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 4'b0000);
    checkOutput("rst_data0", out_data0, 0);
    checkOutput("rst_data1", out_data1, 0);
    checkOutput("rst_data2", out_data2, 0);
    checkOutput("rst_data3", out_data3, 0);
    checkOutput("rst_rr_ptr", rr_ptr, 0);

    applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 8'h5A, 4'b0000);
    checkOutput("release_in_ready", in_ready, 1);
    tick();
    checkOutput("release_out_valid", out_valid, 4'b0100);
    checkOutput("release_data2", out_data2, 8'h5A);

    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 8'h11, 4'b1111);
    checkOutput("sel0_in_ready", in_ready, 1);
    tick();
    checkOutput("sel0_out_valid", out_valid, 4'b0001);
    checkOutput("sel0_data", out_data0, 8'h11);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 8'h22, 4'b1111);
    checkOutput("sel1_in_ready", in_ready, 1);
    tick();
    checkOutput("sel1_out_valid", out_valid, 4'b0010);
    checkOutput("sel1_data", out_data1, 8'h22);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 8'h33, 4'b1111);
    checkOutput("sel2_in_ready", in_ready, 1);
    tick();
    checkOutput("sel2_out_valid", out_valid, 4'b0100);
    checkOutput("sel2_data", out_data2, 8'h33);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, 8'h44, 4'b1111);
    checkOutput("sel3_in_ready", in_ready, 1);
    tick();
    checkOutput("sel3_out_valid", out_valid, 4'b1000);
    checkOutput("sel3_data", out_data3, 8'h44);
    checkOutput("sel_rr_ptr", rr_ptr, 0);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 4'b1111);
    tick();
    checkOutput("sel_drained", out_valid, 4'b0000);

    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 8'hA1, 4'b1101);
    checkOutput("bp_a1_in_ready", in_ready, 1);
    tick();
    checkOutput("bp_a1_out_valid", out_valid, 4'b0010);
    checkOutput("bp_a1_data", out_data1, 8'hA1);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 8'hA2, 4'b1101);
    checkOutput("bp_lane1_full", in_ready, 0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 8'hB0, 4'b1101);
    checkOutput("bp_b0_in_ready", in_ready, 1);
    tick();
    checkOutput("bp_b0_out_valid", out_valid, 4'b0011);
    checkOutput("bp_b0_data", out_data0, 8'hB0);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 8'hA2, 4'b1101);
    checkOutput("bp_a2_blocked", in_ready, 0);
    tick();
    checkOutput("bp_hold_out_valid", out_valid, 4'b0010);
    checkOutput("bp_hold_data", out_data1, 8'hA1);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 8'hA2, 4'b1111);
    checkOutput("bp_release_in_ready", in_ready, 1);
    tick();
    checkOutput("bp_swap_out_valid", out_valid, 4'b0010);
    checkOutput("bp_swap_data", out_data1, 8'hA2);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 4'b1111);
    tick();
    checkOutput("bp_drained", out_valid, 4'b0000);

    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 8'(k), 4'b1111);
      checkOutput("rr_in_ready", in_ready, 1);
      tick();
      checkOutput("rr_out_valid", out_valid, 32'(4'b0001 << ((k - 1) % 4)));
      checkOutput("rr_data", laneData((k - 1) % 4), 32'(k));
    end
    checkOutput("rr_final_ptr", rr_ptr, 2);

    applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 8'h03, 4'b1011);
    tick();
    checkOutput("stall_fill_out_valid", out_valid, 4'b0100);
    checkOutput("stall_fill_ptr", rr_ptr, 2);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 8'h07, 4'b1011);
    checkOutput("stall_in_ready", in_ready, 0);
    tick();
    checkOutput("stall_ptr_a", rr_ptr, 2);
    checkOutput("stall_data2", out_data2, 8'h03);
    tick();
    checkOutput("stall_ptr_b", rr_ptr, 2);
    checkOutput("stall_in_ready_b", in_ready, 0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 8'h07, 4'b1111);
    checkOutput("unstall_in_ready", in_ready, 1);
    tick();
    checkOutput("unstall_out_valid", out_valid, 4'b0100);
    checkOutput("unstall_data2", out_data2, 8'h07);
    checkOutput("unstall_ptr", rr_ptr, 3);

    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 8'h0A, 4'b1111);
    tick();
    checkOutput("tog_a_out_valid", out_valid, 4'b0001);
    checkOutput("tog_a_data0", out_data0, 8'h0A);
    checkOutput("tog_a_ptr", rr_ptr, 3);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 8'h0B, 4'b1111);
    tick();
    checkOutput("tog_b_data0", out_data0, 8'h0B);
    checkOutput("tog_b_ptr", rr_ptr, 3);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 8'h0C, 4'b1111);
    tick();
    checkOutput("tog_c_out_valid", out_valid, 4'b1000);
    checkOutput("tog_c_data3", out_data3, 8'h0C);
    checkOutput("tog_c_ptr", rr_ptr, 0);

    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 8'h0D, 4'b0000);
    tick();
    checkOutput("mid_pre_out_valid", out_valid, 4'b1001);
    checkOutput("mid_pre_data0", out_data0, 8'h0D);
    checkOutput("mid_pre_ptr", rr_ptr, 1);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'h0E, 4'b0000);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    tick();
    checkOutput("mid_rst_out_valid", out_valid, 4'b0000);
    checkOutput("mid_rst_ptr", rr_ptr, 0);
    checkOutput("mid_rst_data1", out_data1, 0);
    checkOutput("mid_rst_data0", out_data0, 0);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'b0000);
    tick();
    checkOutput("post_rst_out_valid", out_valid, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
